frame_loader: RTL and testbench
===============================

// Module: frame_loader
// PURPOSE
//  Write side of the 450x450 8-bit grayscale frame buffer that pixel_Gen scans out.
//  Accepts a raster-ordered pixel byte stream over a valid/ready handshake, for example from the filter core or the UART loader.
//  Writes each byte to the buffer at base(selectImage) + y*IMG_W + x.
//  Same row-major layout that pixel_Gen reads with addr = (pixel_y-24)*450 + (pixel_x-160).
// PARAMETERS
//  IMG_W   450   pixels per row
//  IMG_H   450   rows per frame
//  ADDR_W  32    width of wr_addr; matches the 32-bit read address of the frame buffer
// PORTS
//  clk          in   1       system clock; all logic rising-edge
//  reset        in   1       synchronous, active-high reset
//  start        in   1       begin loading a frame; sampled only in IDLE
//  abort        in   1       cancel the current load; sampled only in RUN
//  selectImage  in   2       frame slot 0..3 (LENNA/BOATS/BARBARA/FILTER); latched at start
//  in_valid     in   1       in_data holds a pixel
//  in_data      in   8       pixel value, raster order, top-left first
//  in_ready     out  1       loader can accept a pixel this cycle
//  wr_en        out  1       frame buffer write strobe
//  wr_addr      out  ADDR_W  frame buffer write address
//  wr_data      out  8       frame buffer write data
//  busy         out  1       high while a frame is being loaded
//  frame_done   out  1       1-cycle pulse when the last pixel is written
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready, wr_en, busy and frame_done are 0; wr_addr=0, wr_data=0; all counters 0.
//    Reset in any state, mid-frame included, takes effect on the next edge.
//    No further writes occur after reset.
//  - FRAME = IMG_W*IMG_H. base = selectImage*FRAME, zero-extended to ADDR_W.
//    Slot bases are 0, 202500, 405000, 607500.
//  - States:
//    - IDLE: start=1 latches selectImage and sets the address counter to base, x=0, y=0, then -> RUN.
//      abort is ignored in IDLE.
//    - RUN: pixels are accepted.
//      abort=1 -> IDLE with no frame_done; any byte offered in that cycle is dropped (abort wins).
//      Accepting pixel (x=IMG_W-1, y=IMG_H-1) -> DONE.
//    - DONE: one cycle, then -> IDLE.
//      start is ignored in RUN and DONE; there is no queueing.
//  - in_ready = (state==RUN) & ~abort.
//    A transfer occurs when in_valid & in_ready is high at the clock edge.
//  - Each transfer registers wr_en=1, wr_addr=current address, wr_data=in_data for the next cycle only.
//    Latency is 1 cycle; wr_en=0 on every cycle that follows a cycle with no transfer.
//  - Address generation is incremental with no multiplier: address +1 per transfer.
//    x is 0..IMG_W-1; at x=IMG_W-1, x wraps to 0 and y increments.
//  - frame_done=1 in the DONE cycle, which is the same cycle as the last wr_en (address base+FRAME-1).
//  - busy=1 in RUN and DONE.
//  - in_valid with no handshake (IDLE/DONE) never produces wr_en; in_data is don't-care when in_valid=0.
//  - After DONE or abort, a new start restarts at the new base with x=y=0.
// TESTING
//  1. reset, start with sel=0, 202500 back-to-back bytes (data=addr[7:0]):
//     wr_addr 0..202499 contiguous, wr_data matches, frame_done=1 exactly once, in the cycle with wr_addr=202499.
//  2. sel=2 full frame: first wr_addr=405000, last=607499; in_ready=0 from the cycle after the last transfer.
//  3. in_valid toggled 1-0-0-1 with random gaps: no wr_en on gap cycles, addresses stay contiguous,
//     each write lands one cycle after its transfer.
//  4. Row wrap: 450th byte -> wr_addr 449, 451st -> wr_addr 450; internal x=0, y=1 after it.
//  5. abort after 1000 transfers, with in_valid=1 in the abort cycle:
//     - last wr_addr=999, no frame_done.
//     - start asserted during RUN earlier is ignored.
//     - a new start (sel=1) begins at 202500.
//  6. reset asserted mid-frame with in_valid=1: next cycle wr_en=0, busy=0, in_ready=0;
//     a subsequent start writes from the slot base again.

Source files
------------

// File: rtl/frame_loader.sv
// frame_loader: write side of the 8-bit grayscale frame buffer scanned out by
// pixel_Gen. A raster-ordered byte stream arrives over a valid/ready handshake
// and each byte is written to base(selectImage) + y*IMG_W + x.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   start                  begin loading a frame (honoured only when idle)
//   abort                  cancel the current load (honoured only while running)
//   selectImage[1:0]       frame slot 0..3, latched at start
//   in_valid, in_data[7:0] pixel stream, top-left first
//   in_ready               loader accepts a pixel this cycle
//   wr_en, wr_addr, wr_data  frame buffer write port, one cycle after transfer
//   busy                   high while a frame is loading (RUN and DONE)
//   frame_done             one-cycle pulse alongside the last pixel write
module frame_loader #(
  parameter int IMG_W  = 450,
  parameter int IMG_H  = 450,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        selectImage,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int FRAME = IMG_W * IMG_H;
  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Slot bases are elaboration-time constants, so no multiplier is built.
  function automatic logic [ADDR_W-1:0] slot_base(input logic [1:0] sel);
    logic [ADDR_W-1:0] b;
    case (sel)
      2'd0:    b = '0;
      2'd1:    b = ADDR_W'(FRAME);
      2'd2:    b = ADDR_W'(2 * FRAME);
      default: b = ADDR_W'(3 * FRAME);
    endcase
    return b;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    x_d       = x_q;
    y_d       = y_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = slot_base(selectImage);
          x_d     = '0;
          y_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // abort takes priority: a byte offered in the abort cycle is dropped.
        if (abort) begin
          state_d = S_IDLE;
        end else if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = in_data;
          addr_d    = addr_q + 1'b1;
          if (x_q == XW'(IMG_W - 1)) begin
            x_d = '0;
            if (y_q == YW'(IMG_H - 1)) begin
              y_d     = '0;
              state_d = S_DONE;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign in_ready   = (state_q == S_RUN) & ~abort;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = (state_q != S_IDLE);
  // The DONE cycle coincides with the registered write of the last pixel.
  assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_frame_loader.sv
module tb_frame_loader;
  localparam int W      = 20;
  localparam int H      = 12;
  localparam int FR     = W * H;
  localparam int BIG_FR = 450 * 450;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort, in_valid;
  logic [1:0]  sel;
  logic [7:0]  in_data;

  logic        in_ready, wr_en, busy, frame_done;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;

  logic        b_in_ready, b_wr_en, b_busy, b_frame_done;
  logic [31:0] b_wr_addr;
  logic [7:0]  b_wr_data;

  frame_loader #(.IMG_W(W), .IMG_H(H), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .selectImage(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .frame_done(frame_done)
  );

  frame_loader big (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .selectImage(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready), .wr_en(b_wr_en),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data), .busy(b_busy), .frame_done(b_frame_done)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase 0 idle, 1 loading, 2 last-pixel cycle; m_n pixels accepted.
  int          phase = 0;
  int          m_base = 0;
  int          m_n = 0;
  logic        m_wr_en;
  logic [31:0] m_addr;
  logic [7:0]  m_data;
  int          done_seen = 0;
  int          done_exp  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic a, input logic [1:0] sl,
                      input logic v, input logic [7:0] d);
    reset = r; start = s; abort = a; sel = sl; in_valid = v; in_data = d;
    #1;
    check("in_ready_pre", in_ready, (phase == 1) && !a);
    check("busy_pre", busy, phase != 0);
    check("frame_done_pre", frame_done, phase == 2);
    @(posedge clk);
    #1;
    m_wr_en = 1'b0;
    if (r) begin
      phase = 0; m_n = 0; m_addr = '0; m_data = '0;
    end else begin
      case (phase)
        0: if (s) begin m_base = int'(sl) * FR; m_n = 0; phase = 1; end
        1: begin
          if (a) phase = 0;
          else if (v) begin
            m_wr_en = 1'b1;
            m_addr  = 32'(m_base + m_n);
            m_data  = d;
            m_n++;
            if (m_n == FR) begin phase = 2; done_exp++; end
          end
        end
        default: phase = 0;
      endcase
    end
    if (frame_done === 1'b1) done_seen++;
    check("wr_en", wr_en, m_wr_en);
    if (m_wr_en || r) begin
      check("wr_addr", wr_addr, m_addr);
      check("wr_data", wr_data, m_data);
    end
    check("busy", busy, phase != 0);
    check("frame_done", frame_done, phase == 2);
    check("in_ready", in_ready, (phase == 1) && !a);
    if (phase == 1) begin
      check("x", dut.x_q, m_n % W);
      check("y", dut.y_q, m_n / W);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; sel = 2'd0; in_valid = 1'b0; in_data = 8'd0;
    @(posedge clk); #1;

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 8'h5A);
    check("big_reset_wr_en", b_wr_en, 0);
    check("big_reset_wr_addr", b_wr_addr, 0);
    check("big_reset_busy", b_busy, 0);

    // Back-to-back frame in slot 0, data = low address byte, stray starts ignored
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < FR; i++)
      step(0, $urandom_range(0, 3) == 0, 0, 2'($urandom), 1, 8'(i));
    step(0, 1, 0, 1, 1, 8'hAA);   // start and valid in the DONE cycle are ignored
    step(0, 0, 0, 0, 1, 8'h55);   // valid while idle writes nothing
    step(0, 0, 1, 0, 0, 0);       // abort while idle is ignored
    check("frames_after_1", done_seen, 1);
    check("frames_expected_1", done_seen, done_exp);

    // Slot 2 with random valid gaps and random data
    step(0, 1, 0, 2, 0, 0);
    for (int c = 0; c < 8 * FR && phase == 1; c++)
      step(0, $urandom_range(0, 5) == 0, 0, 2'($urandom), $urandom_range(0, 1) == 1, 8'($urandom));
    check("frame2_reached_done", phase, 2);
    step(0, 0, 0, 0, 1, 8'h11);
    step(0, 0, 0, 0, 1, 8'h22);
    check("frames_after_2", done_seen, 2);

    // Row wrap in slot 3
    step(0, 1, 0, 3, 0, 0);
    for (int i = 0; i < W; i++) step(0, 0, 0, 0, 1, 8'($urandom));
    check("wrap_last_addr", wr_addr, 3 * FR + W - 1);
    check("wrap_x", dut.x_q, 0);
    check("wrap_y", dut.y_q, 1);
    step(0, 0, 0, 0, 1, 8'h3C);
    check("wrap_next_addr", wr_addr, 3 * FR + W);
    step(0, 0, 1, 0, 1, 8'h99);

    // Abort mid-frame with valid high; restart in slot 1
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < FR / 2; i++)
      step(0, $urandom_range(0, 2) == 0, 0, 2'($urandom), 1, 8'($urandom));
    check("abort_last_addr", wr_addr, FR / 2 - 1);
    step(0, 0, 1, 0, 1, 8'hEE);
    check("abort_no_done", done_seen, 2);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 8'h77);
    check("restart_base", wr_addr, FR);

    // Reset mid-frame with valid high, then restart from slot base
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 8'($urandom));
    step(1, 0, 0, 0, 1, 8'h42);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 8'h13);
    check("post_reset_base", wr_addr, 0);
    step(0, 0, 1, 0, 0, 0);

    // Full-size slot bases
    for (int k = 1; k < 4; k++) begin
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 2'(k), 0, 0);
      step(0, 0, 0, 0, 1, 8'(k + 8'h60));
      check("big_wr_en", b_wr_en, 1);
      check("big_base", b_wr_addr, k * BIG_FR);
      check("big_wr_data", b_wr_data, k + 8'h60);
      step(0, 0, 1, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
